usb_console_line_rx: RTL

- Host-facing end of the CDC debug console: consumes the byte stream the CDC endpoint delivers on its debug_rx side.
- Assembles bytes into command lines with line editing (backspace, cancel, CR/LF/CRLF termination).
- Echoes characters back over the CDC debug_tx side.
- Presents each completed line to the command dispatcher through a random-access read port with a valid/ack handshake.

---
 rtl/usb_console_line_rx.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_console_line_rx.sv
// CDC debug console line receiver: edits incoming bytes into a line buffer, echoes them and
// hands completed lines to the dispatcher. Define CONSOLE_ECHO_EN to enable echo generation.
module usb_console_line_rx #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              dtr,
    output logic              cmd_valid,
    output logic [ADDR_W:0]   cmd_len,
    input  logic [ADDR_W-1:0] cmd_rd_addr,
    output logic [7:0]        cmd_rd_data,
    input  logic              cmd_ack,
    output logic [7:0]        ovf_count
);
    localparam int              DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL  = (ADDR_W + 1)'(DEPTH);
`ifdef CONSOLE_ECHO_EN
    localparam bit ECHO_EN = 1'b1;
`else
    localparam bit ECHO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {COLLECT, ECHO, WAIT_ACK} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              ovf_q, ovf_d;
    logic              prev_cr_q, prev_cr_d;
    logic              dtr_prev_q, dtr_prev_d;
    logic [7:0]        echo0_q, echo0_d;
    logic [7:0]        echo1_q, echo1_d;
    logic [1:0]        echo_cnt_q, echo_cnt_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              pend_q, pend_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [ADDR_W:0]   cmd_len_q, cmd_len_d;
    logic [7:0]        ovf_count_q, ovf_count_d;
    logic              rx_ready_q, rx_ready_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        line_mem [DEPTH];

    logic              fire;
    logic              dtr_fall;

    assign fire     = rx_valid && rx_ready_q;
    assign dtr_fall = dtr_prev_q && !dtr;

    // NOTE: every variable gets its default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        logic [1:0] n_echo;
        logic [7:0] e0, e1, e2;
        logic       term, issue;

        state_d     = state_q;
        len_d       = len_q;
        ovf_d       = ovf_q;
        prev_cr_d   = prev_cr_q;
        dtr_prev_d  = dtr;
        echo0_d     = echo0_q;
        echo1_d     = echo1_q;
        echo_cnt_d  = echo_cnt_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        pend_d      = pend_q;
        cmd_valid_d = cmd_valid_q;
        cmd_len_d   = cmd_len_q;
        ovf_count_d = ovf_count_q;
        rd_data_d   = line_mem[cmd_rd_addr];
        wr_en       = 1'b0;
        wr_addr     = len_q[ADDR_W-1:0];
        n_echo      = 2'd0;
        e0          = 8'h00;
        e1          = 8'h00;
        e2          = 8'h00;
        term        = 1'b0;
        issue       = 1'b0;

        case (state_q)
            COLLECT: begin
                // A byte arriving on the same edge as a terminal disconnect is discarded with the line.
                if (dtr_fall) begin
                    len_d = '0;
                    ovf_d = 1'b0;
                end else if (fire) begin
                    prev_cr_d = (rx_data == 8'h0D);
                    if (rx_data inside {[8'h20:8'h7E]}) begin
                        n_echo = 2'd1;
                        if (len_q < FULL) begin
                            wr_en = 1'b1;
                            len_d = len_q + 1'b1;
                            e0    = rx_data;
                        end else begin
                            ovf_d = 1'b1;
                            e0    = 8'h07;
                        end
                    end else if (rx_data == 8'h08 || rx_data == 8'h7F) begin
                        if (len_q != '0) begin
                            len_d  = len_q - 1'b1;
                            n_echo = 2'd3;
                            e0     = 8'h08;
                            e1     = 8'h20;
                            e2     = 8'h08;
                        end
                    end else if (rx_data == 8'h0D || (rx_data == 8'h0A && !prev_cr_q)) begin
                        term = 1'b1;
                    end else if (rx_data == 8'h03) begin
                        len_d  = '0;
                        ovf_d  = 1'b0;
                        n_echo = 2'd2;
                        e0     = 8'h0D;
                        e1     = 8'h0A;
                    end

                    if (term) begin
                        n_echo = 2'd2;
                        e0     = 8'h0D;
                        e1     = 8'h0A;
                        if (ovf_q) begin
                            if (ovf_count_q != 8'hFF) ovf_count_d = ovf_count_q + 8'd1;
                            len_d = '0;
                            ovf_d = 1'b0;
                        end else if (len_q != '0) begin
                            issue = 1'b1;
                        end
                    end

                    if (ECHO_EN && n_echo != 2'd0) begin
                        tx_data_d  = e0;
                        tx_valid_d = dtr;
                        echo0_d    = e1;
                        echo1_d    = e2;
                        echo_cnt_d = n_echo - 2'd1;
                        pend_d     = issue;
                        state_d    = ECHO;
                    end else if (issue) begin
                        cmd_valid_d = 1'b1;
                        cmd_len_d   = len_q;
                        state_d     = WAIT_ACK;
                    end
                end
            end
            ECHO: begin
                if (dtr_fall) begin
                    tx_valid_d = 1'b0;
                    echo_cnt_d = 2'd0;
                    pend_d     = 1'b0;
                    len_d      = '0;
                    ovf_d      = 1'b0;
                    state_d    = COLLECT;
                end else if (!tx_valid_q || tx_ready) begin
                    // With no terminal attached the byte was never offered, so it retires at once.
                    if (echo_cnt_q != 2'd0) begin
                        tx_data_d  = echo0_q;
                        tx_valid_d = dtr;
                        echo0_d    = echo1_q;
                        echo_cnt_d = echo_cnt_q - 2'd1;
                    end else begin
                        tx_valid_d = 1'b0;
                        pend_d     = 1'b0;
                        if (pend_q) begin
                            cmd_valid_d = 1'b1;
                            cmd_len_d   = len_q;
                            state_d     = WAIT_ACK;
                        end else begin
                            state_d = COLLECT;
                        end
                    end
                end
            end
            WAIT_ACK: begin
                if (cmd_ack) begin
                    cmd_valid_d = 1'b0;
                    len_d       = '0;
                    state_d     = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        rx_ready_d = (state_d == COLLECT);
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            len_q       <= '0;
            ovf_q       <= 1'b0;
            prev_cr_q   <= 1'b0;
            dtr_prev_q  <= 1'b0;
            echo0_q     <= 8'h00;
            echo1_q     <= 8'h00;
            echo_cnt_q  <= 2'd0;
            tx_data_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
            pend_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_len_q   <= '0;
            ovf_count_q <= 8'h00;
            rx_ready_q  <= 1'b0;
            rd_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ovf_q       <= ovf_d;
            prev_cr_q   <= prev_cr_d;
            dtr_prev_q  <= dtr_prev_d;
            echo0_q     <= echo0_d;
            echo1_q     <= echo1_d;
            echo_cnt_q  <= echo_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            pend_q      <= pend_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_len_q   <= cmd_len_d;
            ovf_count_q <= ovf_count_d;
            rx_ready_q  <= rx_ready_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // NOTE: the line buffer is deliberately not reset; len gates which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) line_mem[wr_addr] <= rx_data;
    end

    assign rx_ready    = rx_ready_q;
    assign tx_valid    = ECHO_EN ? tx_valid_q : 1'b0;
    assign tx_data     = ECHO_EN ? tx_data_q : 8'h00;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_len     = cmd_len_q;
    assign cmd_rd_data = rd_data_q;
    assign ovf_count   = ovf_count_q;

endmodule
